alu_arbiter: RTL and testbench

Shares the single-cycle combinational ALU between two requesters, e.g. the EXU and a multi-cycle helper unit, using valid/ready handshakes. It accepts one operation at a time and drives the ALU from registered operands. It captures the result and zero flag, then returns them to the granting requester. Both requesters have equal standing; when both are valid, a round-robin pointer decides who is served.

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin winner selection in IDLE, registered operands drive the ALU
// during EXEC, and the captured result is held in RESP until accepted.
//
// Handshakes: a transfer on channel i happens in a cycle where both valid[i]
// and ready[i] are high at the rising edge. Requesters hold valid/op/operands
// until ready; req_ready is combinational and never depends on resp_ready.
// resp_valid stays high with a stable result until resp_ready of the granted
// requester is seen.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_gnt;
    logic             r_gnt_id;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_data1;
    logic [WIDTH-1:0] r_alu_data2;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_zero;

    logic             w_win_valid;
    logic             w_win_id;
    logic             w_accept;
    logic             w_resp_hs;
    logic [1:0]       w_req_ready;
    logic [1:0]       w_resp_valid;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Winner selection: a lone valid requester wins; a tie goes to ~last_gnt.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = 1'b0;
        case (req_valid)
            2'b01: begin
                w_win_valid = 1'b1;
                w_win_id    = 1'b0;
            end
            2'b10: begin
                w_win_valid = 1'b1;
                w_win_id    = 1'b1;
            end
            2'b11: begin
                w_win_valid = 1'b1;
                w_win_id    = ~r_last_gnt;
            end
            default: begin
                w_win_valid = 1'b0;
                w_win_id    = 1'b0;
            end
        endcase
    end

    // Operand mux toward the operand registers, steered by the winner.
    always_comb begin
        w_sel_op = w_win_id ? req_op1 : req_op0;
        w_sel_a  = w_win_id ? req_a1  : req_a0;
        w_sel_b  = w_win_id ? req_b1  : req_b0;
    end

    // FSM next state and handshake strobes; req_ready is gated by rst_n so it
    // stays low for the whole reset pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 2'b00;
        w_resp_valid = 2'b00;
        w_accept     = 1'b0;
        w_resp_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid && rst_n) begin
                    w_req_ready[w_win_id] = 1'b1;
                    w_accept              = 1'b1;
                    w_state_nxt           = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_resp_valid[r_gnt_id] = 1'b1;
                if (resp_ready[r_gnt_id]) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: who is being served and who was served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_id   <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            if (w_accept) begin
                r_gnt_id <= w_win_id;
            end
            if (w_resp_hs) begin
                r_last_gnt <= r_gnt_id;
            end
        end
    end

    // Operand registers: loaded on accept, otherwise they keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op    <= 4'b0000;
            r_alu_data1 <= '0;
            r_alu_data2 <= '0;
        end else if (w_accept) begin
            r_alu_op    <= w_sel_op;
            r_alu_data1 <= w_sel_a;
            r_alu_data2 <= w_sel_b;
        end
    end

    // Result capture at the end of EXEC; held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_resp_result <= alu_result;
            r_resp_zero   <= alu_zero;
        end
    end

    assign req_ready   = w_req_ready;
    assign resp_valid  = w_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign alu_op      = r_alu_op;
    assign alu_data1   = r_alu_data1;
    assign alu_data2   = r_alu_data2;
    assign busy        = (r_state == EXEC) || (r_state == RESP);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU
// attached to the alu_* ports. Inputs change 1 ns after a rising edge,
// outputs are checked on the falling edge.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op0;
    logic [3:0]   req_op1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_b1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_data1;
    logic [W-1:0] alu_data2;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_fail;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_op      (alu_op),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-cycle ALU.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_data1 + alu_data2;
            4'b0001: alu_result = alu_data1 - alu_data2;
            4'b0010: alu_result = alu_data1 << alu_data2[4:0];
            4'b0100: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
            4'b0110: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
            4'b1000: alu_result = alu_data1 ^ alu_data2;
            4'b1010: alu_result = alu_data1 >> alu_data2[4:0];
            4'b1011: alu_result = W'($signed(alu_data1) >>> alu_data2[4:0]);
            4'b1100: alu_result = alu_data1 | alu_data2;
            4'b1110: alu_result = alu_data1 & alu_data2;
            default: alu_result = alu_data2;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b00;
        req_op0    = 4'b0000;
        req_op1    = 4'b0000;
        req_a0     = '0;
        req_a1     = '0;
        req_b0     = '0;
        req_b1     = '0;

        // Reset state, with both requesters valid during reset.
        repeat (2) tick();
        samp();
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'h0);
        check_eq("rst_alu_op", 32'(alu_op), 32'h0);
        check_eq("rst_data1", alu_data1, 32'h0);
        check_eq("rst_data2", alu_data2, 32'h0);
        check_eq("rst_result", resp_result, 32'h0);
        check_eq("rst_zero", 32'(resp_zero), 32'h0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;

        // Single add on r0: 5 + 3 = 8.
        tick();
        req_valid  = 2'b01;
        req_op0    = 4'b0000;
        req_a0     = 32'd5;
        req_b0     = 32'd3;
        resp_ready = 2'b11;
        samp();
        check_eq("add_ready_c0", 32'(req_ready), 32'h1);
        check_eq("add_busy_c0", 32'(busy), 32'h0);
        tick();
        req_valid = 2'b00;
        samp();
        check_eq("add_busy_c1", 32'(busy), 32'h1);
        check_eq("add_state_c1", 32'(dbg_state), 32'h1);
        check_eq("add_rvalid_c1", 32'(resp_valid), 32'h0);
        check_eq("add_data1_c1", alu_data1, 32'd5);
        check_eq("add_data2_c1", alu_data2, 32'd3);
        tick();
        samp();
        check_eq("add_rvalid_c2", 32'(resp_valid), 32'h1);
        check_eq("add_result", resp_result, 32'd8);
        check_eq("add_zero", 32'(resp_zero), 32'h0);
        check_eq("add_busy_c2", 32'(busy), 32'h1);
        tick();
        samp();
        check_eq("add_busy_c3", 32'(busy), 32'h0);
        check_eq("add_rvalid_c3", 32'(resp_valid), 32'h0);

        // Zero flag: r1 sub 7 - 7.
        req_valid = 2'b10;
        req_op1   = 4'b0001;
        req_a1    = 32'd7;
        req_b1    = 32'd7;
        tick();
        req_valid = 2'b00;
        samp();
        check_eq("sub_state_c1", 32'(dbg_state), 32'h1);
        tick();
        samp();
        check_eq("sub_rvalid", 32'(resp_valid), 32'h2);
        check_eq("sub_result", resp_result, 32'h0);
        check_eq("sub_zero", 32'(resp_zero), 32'h1);
        tick();

        // Contention from reset: r0 and, r1 or.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_op0   = 4'b1110;
        req_a0    = 32'h0F;
        req_b0    = 32'hFF;
        req_op1   = 4'b1100;
        req_a1    = 32'hF0;
        req_b1    = 32'h0F;
        samp();
        check_eq("cont_ready_c0", 32'(req_ready), 32'h1);
        tick();
        samp();
        check_eq("cont_ready_c1", 32'(req_ready), 32'h0);
        tick();
        samp();
        check_eq("cont_rvalid_c2", 32'(resp_valid), 32'h1);
        check_eq("cont_result0", resp_result, 32'h0F);
        check_eq("cont_ready_c2", 32'(req_ready), 32'h0);
        tick();
        samp();
        check_eq("cont_ready_c3", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        samp();
        tick();
        samp();
        check_eq("cont_rvalid_c5", 32'(resp_valid), 32'h2);
        check_eq("cont_result1", resp_result, 32'hFF);
        tick();

        // Backpressure: r0 sltu 1 < 2, response held for 4 cycles.
        req_valid  = 2'b01;
        req_op0    = 4'b0110;
        req_a0     = 32'd1;
        req_b0     = 32'd2;
        resp_ready = 2'b00;
        samp();
        check_eq("bp_ready_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        req_op1   = 4'b0000;
        req_a1    = 32'd10;
        req_b1    = 32'd20;
        samp();
        check_eq("bp_ready_c1", 32'(req_ready), 32'h0);
        tick();
        resp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            samp();
            check_eq("bp_hold_rvalid", 32'(resp_valid), 32'h1);
            check_eq("bp_hold_result", resp_result, 32'd1);
            check_eq("bp_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end
        resp_ready = 2'b01;
        samp();
        check_eq("bp_hs_rvalid", 32'(resp_valid), 32'h1);
        check_eq("bp_hs_ready", 32'(req_ready), 32'h0);
        tick();
        samp();
        check_eq("bp_next_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        samp();
        tick();
        samp();
        check_eq("bp_r1_rvalid", 32'(resp_valid), 32'h2);
        check_eq("bp_r1_result", resp_result, 32'd30);
        tick();

        // Round-robin: r0 xor, r1 signed slt of -1 vs 1.
        req_valid = 2'b11;
        req_op0   = 4'b1000;
        req_a0    = 32'hFF;
        req_b0    = 32'h0F;
        req_op1   = 4'b0100;
        req_a1    = 32'hFFFF_FFFF;
        req_b1    = 32'd1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_oh;
            logic [31:0] exp_res;
            exp_oh  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (i % 2 == 0) ? 32'hF0 : 32'd1;
            samp();
            check_eq("rr_grant", 32'(req_ready), 32'(exp_oh));
            tick();
            samp();
            check_eq("rr_busy", 32'(busy), 32'h1);
            tick();
            samp();
            check_eq("rr_rvalid", 32'(resp_valid), 32'(exp_oh));
            check_eq("rr_result", resp_result, exp_res);
            tick();
        end
        req_valid = 2'b00;

        // Reset during EXEC.
        req_valid = 2'b01;
        req_op0   = 4'b1000;
        req_a0    = 32'h55;
        req_b0    = 32'hAA;
        tick();
        req_valid = 2'b00;
        samp();
        check_eq("rexec_state_pre", 32'(dbg_state), 32'h1);
        check_eq("rexec_op_pre", 32'(alu_op), 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rexec_rvalid", 32'(resp_valid), 32'h0);
        check_eq("rexec_state", 32'(dbg_state), 32'h0);
        check_eq("rexec_op", 32'(alu_op), 32'h0);
        check_eq("rexec_data1", alu_data1, 32'h0);
        check_eq("rexec_busy", 32'(busy), 32'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b10;
        req_op1   = 4'b0000;
        req_a1    = 32'd2;
        req_b1    = 32'd3;
        samp();
        check_eq("rexec_r1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        samp();
        tick();
        samp();
        check_eq("rexec_r1_rvalid", 32'(resp_valid), 32'h2);
        check_eq("rexec_r1_result", resp_result, 32'd5);
        tick();

        // Reset during RESP drops the pending response.
        req_valid = 2'b01;
        req_op0   = 4'b0000;
        req_a0    = 32'd4;
        req_b0    = 32'd4;
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        samp();
        tick();
        samp();
        check_eq("rresp_rvalid_pre", 32'(resp_valid), 32'h1);
        check_eq("rresp_result_pre", resp_result, 32'd8);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rresp_rvalid", 32'(resp_valid), 32'h0);
        check_eq("rresp_result", resp_result, 32'h0);
        check_eq("rresp_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
